// File: rtl/divider_pkg.sv
// Shared definitions for the sequential arithmetic blocks: state encodings
// and constant helpers used for sizing and parameter checks.
package divider_pkg;

  localparam int N_WIDTH_DEF = 20;
  localparam int D_WIDTH_DEF = 10;

  // Encodings shared with other sequential arithmetic blocks.
  localparam logic [1:0] SEQ_IDLE = 2'd0;
  localparam logic [1:0] SEQ_CALC = 2'd1;
  localparam logic [1:0] SEQ_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = SEQ_IDLE,
    ST_CALC = SEQ_CALC,
    ST_DONE = SEQ_DONE
  } state_t;

  // Number of bits needed to hold value (at least 1).
  function automatic int bit_width(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((value >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring division iteration: shift the partial remainder left, bring
// in the next dividend bit, and keep the difference only if it did not borrow.
module divider_step
  import divider_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input  logic [D_WIDTH:0]   rem,
  input  logic [D_WIDTH-1:0] divisor,
  input  logic               next_bit,
  output logic [D_WIDTH:0]   rem_next,
  output logic               q_bit
);

  logic [D_WIDTH:0]   shifted;
  logic [D_WIDTH+1:0] diff;
  logic               borrow;
  // The incoming remainder is always below the divisor, so its MSB is zero.
  logic               unused_rem_msb;

  assign unused_rem_msb = rem[D_WIDTH];

  // Trial subtraction with one guard bit to expose the borrow.
  always_comb begin
    shifted  = {rem[D_WIDTH-1:0], next_bit};
    diff     = {1'b0, shifted} - {2'b00, divisor};
    borrow   = diff[D_WIDTH+1];
    q_bit    = ~borrow;
    rem_next = borrow ? shifted : diff[D_WIDTH:0];
  end

endmodule

// File: rtl/divider.sv
// Iterative unsigned radix-2 restoring divider, one quotient bit per enabled
// clock, valid/ready handshakes on both sides and a global stall.
//
//  state | meaning
//  IDLE  | ready for operands (ready_o when not stalled)
//  CALC  | one restoring step per enabled edge, counter counts down
//  DONE  | result held on valid_o until ready_i
module divider
  import divider_pkg::*;
#(
  parameter int N_WIDTH = N_WIDTH_DEF,
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input  logic               clk_i,
  input  logic               reset_an_i,
  input  logic               reset_i,
  input  logic               stall_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [N_WIDTH-1:0] data_n_i,
  input  logic [D_WIDTH-1:0] data_d_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [N_WIDTH-1:0] data_q_o,
  output logic [D_WIDTH-1:0] data_r_o,
  output logic               div_zero_o
);

  localparam int CW = bit_width(N_WIDTH - 1);

  if (N_WIDTH < 2 || D_WIDTH < 1 || max_int(N_WIDTH, D_WIDTH) != N_WIDTH
      || min_int(D_WIDTH, 1) != 1) begin : g_bad_param
    $error("divider: need N_WIDTH >= 2 and 1 <= D_WIDTH <= N_WIDTH");
  end

  state_t             state;
  logic [CW-1:0]      cnt;
  // Dividend bits shift out of the top while quotient bits shift in below.
  logic [N_WIDTH-1:0] nq_sh;
  logic [D_WIDTH-1:0] divisor;
  logic [D_WIDTH:0]   rem;
  logic [D_WIDTH:0]   rem_next;
  logic               q_bit;

  divider_step #(.D_WIDTH(D_WIDTH)) u_step (
    .rem      (rem),
    .divisor  (divisor),
    .next_bit (nq_sh[N_WIDTH-1]),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign ready_o = (state == ST_IDLE) && !stall_i;

  // FSM, iteration counter and result registers; frozen while stalled.
  always_ff @(posedge clk_i or negedge reset_an_i) begin
    if (!reset_an_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      nq_sh      <= '0;
      divisor    <= '0;
      rem        <= '0;
      valid_o    <= 1'b0;
      data_q_o   <= '0;
      data_r_o   <= '0;
      div_zero_o <= 1'b0;
    end else if (reset_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      nq_sh      <= '0;
      divisor    <= '0;
      rem        <= '0;
      valid_o    <= 1'b0;
      data_q_o   <= '0;
      data_r_o   <= '0;
      div_zero_o <= 1'b0;
    end else if (!stall_i) begin
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            nq_sh   <= data_n_i;
            divisor <= data_d_i;
            rem     <= '0;
            cnt     <= CW'(N_WIDTH - 1);
            state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          rem   <= rem_next;
          nq_sh <= {nq_sh[N_WIDTH-2:0], q_bit};
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            state      <= ST_DONE;
            valid_o    <= 1'b1;
            data_q_o   <= {nq_sh[N_WIDTH-2:0], q_bit};
            data_r_o   <= rem_next[D_WIDTH-1:0];
            div_zero_o <= (divisor == '0);
          end
        end
        ST_DONE: begin
          if (ready_i) begin
            state   <= ST_IDLE;
            valid_o <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the divider: directed vectors plus a back-to-back
// random sweep, checked against an arithmetic reference model.
module tb_divider;

  localparam int NW = 20;
  localparam int DW = 10;

  logic          clk_i = 1'b0;
  logic          reset_an_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          stall_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [NW-1:0] data_n_i = '0;
  logic [DW-1:0] data_d_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic [NW-1:0] data_q_o;
  logic [DW-1:0] data_r_o;
  logic          div_zero_o;

  divider #(.N_WIDTH(NW), .D_WIDTH(DW)) dut (
    .clk_i      (clk_i),
    .reset_an_i (reset_an_i),
    .reset_i    (reset_i),
    .stall_i    (stall_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_n_i   (data_n_i),
    .data_d_i   (data_d_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .data_q_o   (data_q_o),
    .data_r_o   (data_r_o),
    .div_zero_o (div_zero_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [NW-1:0] q;
    logic [DW-1:0] r;
    logic          dz;
  } res_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  res_t exp_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Reference: plain integer division; zero divisor gives all-ones quotient
  // and the low dividend bits as remainder.
  function automatic res_t model(input int unsigned n, input int unsigned d);
    res_t res;
    if (d == 0) begin
      res.q  = '1;
      res.r  = DW'(n);
      res.dz = 1'b1;
    end else begin
      res.q  = NW'(n / d);
      res.r  = DW'(n % d);
      res.dz = 1'b0;
    end
    return res;
  endfunction

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Every cycle a result is presented it must match the oldest outstanding
  // expectation; it retires when the handshake will complete on the next edge.
  always @(negedge clk_i) begin
    if (reset_an_i && valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_valid: got valid_o=1 expected no result pending");
      end else begin
        chk("cmp_q", longint'(data_q_o), longint'(exp_q[0].q));
        chk("cmp_r", longint'(data_r_o), longint'(exp_q[0].r));
        chk("cmp_dz", longint'(div_zero_o), longint'(exp_q[0].dz));
        if (ready_i && !stall_i && !reset_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // Present operands until accepted; returns just after the accept edge.
  task automatic send(input int unsigned n, input int unsigned d);
    int k;
    valid_i  = 1'b1;
    data_n_i = NW'(n);
    data_d_i = DW'(d);
    k = 0;
    forever begin
      @(negedge clk_i);
      if (ready_o && !stall_i && !reset_i) break;
      k++;
      if (k > 100) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    acc_cyc = cyc;
    exp_q.push_back(model(n, d));
    tick();
    valid_i = 1'b0;
  endtask

  // Count enabled edges from the accept edge until valid_o is seen.
  task automatic wait_valid(input int start, output int lat);
    lat = start;
    forever begin
      @(negedge clk_i);
      if (valid_o) break;
      if (lat > 200) begin
        chk("valid_timeout", 0, 1);
        break;
      end
      tick();
      if (!stall_i) lat++;
    end
  endtask

  res_t m;
  int   lat;
  int   prev_acc;
  int unsigned rn, rd;

  initial begin
    // Model pinned by hand-computed values
    m = model(1000, 7);
    chk("model_q_1000_7", longint'(m.q), 142);
    chk("model_r_1000_7", longint'(m.r), 6);
    m = model(5, 0);
    chk("model_q_div0", longint'(m.q), 20'hFFFFF);
    chk("model_r_div0", longint'(m.r), 5);

    // Reset state
    #12;
    chk("rst_valid", longint'(valid_o), 0);
    chk("rst_q", longint'(data_q_o), 0);
    chk("rst_r", longint'(data_r_o), 0);
    chk("rst_dz", longint'(div_zero_o), 0);
    chk("rst_ready", longint'(ready_o), 1);
    tick();
    reset_an_i = 1'b1;
    tick();

    // 1000/7 with immediate drain
    ready_i = 1'b1;
    send(1000, 7);
    wait_valid(0, lat);
    chk("lat_1000_7", lat, 20);
    chk("q_1000_7", longint'(data_q_o), 142);
    chk("r_1000_7", longint'(data_r_o), 6);
    chk("dz_1000_7", longint'(div_zero_o), 0);
    chk("ready_in_done", longint'(ready_o), 0);
    tick();
    @(negedge clk_i);
    chk("drain_valid", longint'(valid_o), 0);
    chk("drain_ready", longint'(ready_o), 1);
    tick();

    // Boundary operands
    send(1048575, 1023);
    wait_valid(0, lat);
    chk("q_max", longint'(data_q_o), 1025);
    chk("r_max", longint'(data_r_o), 0);
    tick();
    send(3, 1000);
    wait_valid(0, lat);
    chk("q_small", longint'(data_q_o), 0);
    chk("r_small", longint'(data_r_o), 3);
    tick();

    // Divide by zero
    send(5, 0);
    wait_valid(0, lat);
    chk("lat_div0", lat, 20);
    chk("q_div0", longint'(data_q_o), 20'hFFFFF);
    chk("r_div0", longint'(data_r_o), 5);
    chk("dz_div0", longint'(div_zero_o), 1);
    tick();

    // Downstream back-pressure: result held
    ready_i = 1'b0;
    send(1000, 7);
    wait_valid(0, lat);
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("hold_valid", longint'(valid_o), 1);
      chk("hold_ready", longint'(ready_o), 0);
      chk("hold_q", longint'(data_q_o), 142);
      chk("hold_r", longint'(data_r_o), 6);
      tick();
    end
    ready_i = 1'b1;
    tick();
    @(negedge clk_i);
    chk("hold_drain_valid", longint'(valid_o), 0);
    chk("hold_drain_ready", longint'(ready_o), 1);
    tick();

    // Stall for 4 cycles mid-calculation
    send(1000, 7);
    repeat (8) tick();
    stall_i = 1'b1;
    repeat (4) tick();
    stall_i = 1'b0;
    wait_valid(8, lat);
    chk("stall_lat_edges", cyc - acc_cyc - 1, 24);
    chk("stall_q", longint'(data_q_o), 142);
    tick();
    tick();

    // Synchronous reset mid-operation
    send(123456, 789);
    repeat (8) tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    chk("srst_valid", longint'(valid_o), 0);
    chk("srst_q", longint'(data_q_o), 0);
    chk("srst_r", longint'(data_r_o), 0);
    chk("srst_dz", longint'(div_zero_o), 0);
    chk("srst_ready", longint'(ready_o), 1);
    tick();
    send(1000, 7);
    wait_valid(0, lat);
    chk("post_srst_lat", lat, 20);
    chk("post_srst_q", longint'(data_q_o), 142);
    tick();

    // Asynchronous reset mid-operation
    send(5, 0);
    repeat (8) tick();
    reset_an_i = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_valid", longint'(valid_o), 0);
    chk("arst_q", longint'(data_q_o), 0);
    chk("arst_r", longint'(data_r_o), 0);
    chk("arst_ready", longint'(ready_o), 1);
    tick();
    reset_an_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("arst_no_result", longint'(valid_o), 0);
      tick();
    end
    send(1048575, 1023);
    wait_valid(0, lat);
    chk("post_arst_q", longint'(data_q_o), 1025);
    chk("post_arst_dz", longint'(div_zero_o), 0);
    tick();

    // Back-to-back random sweep
    ready_i  = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 300; i++) begin
      rn = $urandom_range(0, 20'hFFFFF);
      case (i % 5)
        0: rd = $urandom_range(1, 15);
        1: rd = $urandom_range(1, 1023);
        2: rd = 1023;
        3: rd = (i % 15 == 3) ? 0 : $urandom_range(16, 1023);
        default: rd = 1;
      endcase
      send(rn, rd);
      valid_i = 1'b1;
      if (i > 0) chk("b2b_spacing", acc_cyc - prev_acc, 22);
      prev_acc = acc_cyc;
    end
    valid_i = 1'b0;
    wait_valid(0, lat);
    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
